// File: rtl/lockstep_divergence_monitor_if.sv
// Bus bundle between the lockstep pair stimulus side and the divergence monitor.
// Carries the run control, the two PC/Result streams and the captured verdict.
interface lockstep_divergence_monitor_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  // Protocol: no valid/ready pair. start is a level sampled in IDLE/DONE, the
  // streams are sampled on every edge while busy, done pulses once per run, and
  // abort wins over everything.
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pc_golden;
  logic [WIDTH-1:0] result_golden;
  logic [WIDTH-1:0] pc_faulty;
  logic [WIDTH-1:0] result_faulty;

  logic             busy;
  logic             detected;
  logic             done;
  logic [1:0]       outcome;
  logic [CNT_W-1:0] first_cycle;
  logic [WIDTH-1:0] first_pc_golden;
  logic [WIDTH-1:0] first_pc_faulty;
  logic [WIDTH-1:0] first_result_golden;
  logic [WIDTH-1:0] first_result_faulty;
  logic [CNT_W-1:0] mismatch_count;
  logic [1:0]       dbg_state;

  modport master (
    output start, abort, pc_golden, result_golden, pc_faulty, result_faulty,
    input  busy, detected, done, outcome, first_cycle, first_pc_golden,
           first_pc_faulty, first_result_golden, first_result_faulty,
           mismatch_count, dbg_state
  );

  modport slave (
    input  start, abort, pc_golden, result_golden, pc_faulty, result_faulty,
    output busy, detected, done, outcome, first_cycle, first_pc_golden,
           first_pc_faulty, first_result_golden, first_result_faulty,
           mismatch_count, dbg_state
  );
endinterface

// File: rtl/lockstep_divergence_monitor.sv
// Sink-side lockstep checker: samples golden/faulty streams over a bounded window,
// captures the first divergence, counts mismatches and classifies the fault outcome.
module lockstep_divergence_monitor #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 16
) (
  input logic                          clk,
  input logic                          rst,
  lockstep_divergence_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_DIVERGED = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Window index is sized from MAX_CYCLES so a narrow CNT_W cannot cut the run short.
  localparam int               CYC_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CYC_W-1:0] LAST_IDX = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] OUT_MASKED = 2'b01;
  localparam logic [1:0] OUT_DATA   = 2'b10;
  localparam logic [1:0] OUT_CTRL   = 2'b11;

  state_t           r_state;
  state_t           w_next;

  logic [CYC_W-1:0] r_cycle_cnt;
  logic             r_pc_div;
  logic             r_detected;
  logic             r_done;
  logic [1:0]       r_outcome;
  logic [CNT_W-1:0] r_first_cycle;
  logic [WIDTH-1:0] r_first_pc_golden;
  logic [WIDTH-1:0] r_first_pc_faulty;
  logic [WIDTH-1:0] r_first_result_golden;
  logic [WIDTH-1:0] r_first_result_faulty;
  logic [CNT_W-1:0] r_mismatch_count;

  logic             w_pcm;
  logic             w_mm;
  logic             w_sampling;
  logic             w_last;
  logic             w_start;
  logic             w_clear;
  logic             w_detected_fin;
  logic             w_pc_div_nxt;
  logic [1:0]       w_outcome_fin;

  always_comb begin
    w_pcm          = (bus.pc_golden != bus.pc_faulty);
    w_mm           = w_pcm || (bus.result_golden != bus.result_faulty);
    w_sampling     = (r_state == S_RUN) || (r_state == S_DIVERGED);
    w_last         = w_sampling && (r_cycle_cnt == LAST_IDX);
    w_start        = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_clear        = bus.abort || w_start;
    // Verdict on the terminating edge must include that edge's own sample.
    w_detected_fin = r_detected || w_mm;
    w_pc_div_nxt   = r_pc_div || w_pcm;
    if (!w_detected_fin)   w_outcome_fin = OUT_MASKED;
    else if (w_pc_div_nxt) w_outcome_fin = OUT_CTRL;
    else                   w_outcome_fin = OUT_DATA;
  end

  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (bus.start) w_next = S_RUN;
        S_RUN: begin
          if (w_last)    w_next = S_DONE;
          else if (w_mm) w_next = S_DIVERGED;
        end
        S_DIVERGED: if (w_last) w_next = S_DONE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt           <= '0;
      r_pc_div              <= 1'b0;
      r_detected            <= 1'b0;
      r_done                <= 1'b0;
      r_outcome             <= '0;
      r_first_cycle         <= '0;
      r_first_pc_golden     <= '0;
      r_first_pc_faulty     <= '0;
      r_first_result_golden <= '0;
      r_first_result_faulty <= '0;
      r_mismatch_count      <= '0;
    end else if (w_clear) begin
      r_cycle_cnt           <= '0;
      r_pc_div              <= 1'b0;
      r_detected            <= 1'b0;
      r_done                <= 1'b0;
      r_outcome             <= '0;
      r_first_cycle         <= '0;
      r_first_pc_golden     <= '0;
      r_first_pc_faulty     <= '0;
      r_first_result_golden <= '0;
      r_first_result_faulty <= '0;
      r_mismatch_count      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_sampling) begin
        r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
        if (r_state == S_RUN) begin
          if (w_mm) begin
            r_first_cycle         <= CNT_W'(r_cycle_cnt);
            r_first_pc_golden     <= bus.pc_golden;
            r_first_pc_faulty     <= bus.pc_faulty;
            r_first_result_golden <= bus.result_golden;
            r_first_result_faulty <= bus.result_faulty;
            r_detected            <= 1'b1;
            r_mismatch_count      <= CNT_W'(1);
            r_pc_div              <= w_pcm;
          end
        end else begin
          if (w_mm && (r_mismatch_count != CNT_MAX))
            r_mismatch_count <= r_mismatch_count + CNT_W'(1);
          r_pc_div <= w_pc_div_nxt;
        end
        if (w_last) begin
          r_done    <= 1'b1;
          r_outcome <= w_outcome_fin;
        end
      end
    end
  end

  assign bus.busy                = w_sampling;
  assign bus.detected            = r_detected;
  assign bus.done                = r_done;
  assign bus.outcome             = r_outcome;
  assign bus.first_cycle         = r_first_cycle;
  assign bus.first_pc_golden     = r_first_pc_golden;
  assign bus.first_pc_faulty     = r_first_pc_faulty;
  assign bus.first_result_golden = r_first_result_golden;
  assign bus.first_result_faulty = r_first_result_faulty;
  assign bus.mismatch_count      = r_mismatch_count;
  assign bus.dbg_state           = r_state;

endmodule

// File: tb/tb_lockstep_divergence_monitor.sv
// Randomized scoreboard bench for lockstep_divergence_monitor: a window-level
// reference model predicts each run's verdict, a monitor checks it on done.
module tb_lockstep_divergence_monitor;
  localparam int W    = 32;
  localparam int MAXC = 64;

  typedef struct packed {
    logic [1:0]   outcome;
    logic         detected;
    logic [15:0]  first_cycle;
    logic [W-1:0] fpg;
    logic [W-1:0] fpf;
    logic [W-1:0] frg;
    logic [W-1:0] frf;
    logic [15:0]  count;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lockstep_divergence_monitor_if #(.WIDTH(W), .CNT_W(16)) bus  ();
  lockstep_divergence_monitor_if #(.WIDTH(W), .CNT_W(4))  bus4 ();
  lockstep_divergence_monitor_if #(.WIDTH(W), .CNT_W(16)) bus1 ();

  lockstep_divergence_monitor #(.WIDTH(W), .MAX_CYCLES(MAXC), .CNT_W(16)) dut
    (.clk(clk), .rst(rst), .bus(bus));
  lockstep_divergence_monitor #(.WIDTH(W), .MAX_CYCLES(MAXC), .CNT_W(4)) dut4
    (.clk(clk), .rst(rst), .bus(bus4));
  lockstep_divergence_monitor #(.WIDTH(W), .MAX_CYCLES(1), .CNT_W(16)) dut1
    (.clk(clk), .rst(rst), .bus(bus1));

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];

  logic [W-1:0] s_pg [MAXC];
  logic [W-1:0] s_rg [MAXC];
  logic [W-1:0] s_pf [MAXC];
  logic [W-1:0] s_rf [MAXC];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Verdict of a window of n samples, computed directly from the sample lists.
  function automatic res_t model(input int n, input int cnt_max);
    res_t r;
    int   cnt;
    bit   anypc;
    r = '0; cnt = 0; anypc = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit pcm, mm;
      pcm = (s_pg[i] != s_pf[i]);
      mm  = pcm || (s_rg[i] != s_rf[i]);
      if (mm && cnt == 0) begin
        r.first_cycle = 16'(i);
        r.fpg = s_pg[i]; r.fpf = s_pf[i]; r.frg = s_rg[i]; r.frf = s_rf[i];
      end
      if (mm) cnt++;
      if (pcm) anypc = 1'b1;
    end
    r.detected = (cnt > 0);
    r.count    = 16'((cnt > cnt_max) ? cnt_max : cnt);
    r.outcome  = (cnt == 0) ? 2'b01 : (anypc ? 2'b11 : 2'b10);
    return r;
  endfunction

  task automatic gen(input int kind);
    for (int i = 0; i < MAXC; i++) begin
      s_pg[i] = $urandom; s_rg[i] = $urandom;
      s_pf[i] = s_pg[i];  s_rf[i] = s_rg[i];
      case (kind)
        2: if (i >= 10) s_pf[i] = s_pg[i] + 32'd4;
        4: begin
          int r;
          r = $urandom_range(0, 15);
          if (r == 0) s_pf[i] = s_pg[i] ^ (32'h1 << $urandom_range(0, 31));
          if (r == 1) s_rf[i] = s_rg[i] ^ (32'h1 << $urandom_range(0, 31));
        end
        5: if ($urandom_range(0, 5) == 0) s_rf[i] = s_rg[i] ^ (32'h1 << $urandom_range(0, 31));
        default: ;
      endcase
    end
    if (kind == 1) begin s_rg[5] = 32'h10; s_rf[5] = 32'h11; end
    if (kind == 3) s_rf[63] = s_rg[63] ^ 32'h1;
    if (kind == 6) s_rf[12] = s_rg[12] ^ 32'h100;
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {bus.busy, bus.detected, bus.done, bus.outcome,
                           bus.first_cycle, bus.mismatch_count}, '0);
    check({name, "_cap"}, {bus.first_pc_golden, bus.first_pc_faulty,
                           bus.first_result_golden, bus.first_result_faulty}, '0);
  endtask

  // abort_at < 0 runs the full window; otherwise abort (with start) is driven on that index.
  task automatic run(input int kind, input int abort_at);
    res_t pre;
    bit   aborted;
    aborted = 1'b0;
    gen(kind);
    if (abort_at < 0) exp_q.push_back(model(MAXC, 65535));
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      @(negedge clk);
      pre = model(i, 65535);
      check("busy_run", bus.busy, 1'b1);
      check("detected_prefix", bus.detected, pre.detected);
      check("count_prefix", bus.mismatch_count, pre.count);
      bus.start         = ($urandom_range(0, 15) == 0);
      bus.pc_golden     = s_pg[i];
      bus.pc_faulty     = s_pf[i];
      bus.result_golden = s_rg[i];
      bus.result_faulty = s_rf[i];
      if (i == abort_at) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
        aborted   = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    if (aborted) check_zero("abort");
    repeat (3) @(negedge clk);
    if (aborted) check("abort_idle", bus.busy, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest predicted verdict.
  int   busy_len  = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    res_t e;
    if (bus.busy && !prev_busy) busy_len = 1;
    else if (bus.busy)          busy_len++;
    if (bus.done) begin
      check("done_width", prev_done, 1'b0);
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = exp_q.pop_front();
        check("outcome", bus.outcome, e.outcome);
        check("detected", bus.detected, e.detected);
        check("first_cycle", bus.first_cycle, e.first_cycle);
        check("first_pcs", {bus.first_pc_golden, bus.first_pc_faulty}, {e.fpg, e.fpf});
        check("first_results", {bus.first_result_golden, bus.first_result_faulty}, {e.frg, e.frf});
        check("mismatch_count", bus.mismatch_count, e.count);
        check("busy_len", 32'(busy_len), 32'(MAXC));
      end
    end
    prev_busy = bus.busy;
    prev_done = bus.done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start = 0;  bus.abort = 0;  bus.pc_golden = 0;  bus.pc_faulty = 0;
    bus.result_golden = 0;  bus.result_faulty = 0;
    bus4.start = 0; bus4.abort = 0; bus4.pc_golden = 0; bus4.pc_faulty = 0;
    bus4.result_golden = 0; bus4.result_faulty = 0;
    bus1.start = 0; bus1.abort = 0; bus1.pc_golden = 0; bus1.pc_faulty = 0;
    bus1.result_golden = 0; bus1.result_faulty = 0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset_cnt4", {bus4.busy, bus4.done, bus4.outcome, bus4.mismatch_count}, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("post_reset");

    run(0, -1);
    run(1, -1);
    run(2, -1);
    run(3, -1);
    for (int t = 0; t < 4; t++) run(4, -1);
    run(5, -1);
    run(6, 20);
    run(0, -1);
    run(4, MAXC - 1);
    run(2, -1);

    // Saturating counter on the narrow-count instance.
    bus4.pc_golden = $urandom; bus4.pc_faulty = bus4.pc_golden;
    bus4.result_golden = $urandom; bus4.result_faulty = ~bus4.result_golden;
    @(negedge clk); bus4.start = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    k = 0;
    while (!bus4.done && k < 200) begin @(negedge clk); k++; end
    check("sat_done", bus4.done, 1'b1);
    check("sat_count", bus4.mismatch_count, 4'd15);
    check("sat_outcome", bus4.outcome, 2'b10);
    check("sat_first_cycle", bus4.first_cycle, 4'd0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk); bus4.start = 1'b1;
    @(negedge clk); bus4.start = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_busy", bus4.busy, 1'b1);
    #2 rst = 1'b0;
    #1 check("async_clear", {bus4.busy, bus4.detected, bus4.done, bus4.outcome,
                             bus4.mismatch_count, bus4.first_result_faulty}, '0);
    #1 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_done_after_rst", {bus4.done, bus4.busy}, 2'b00);
    end

    // Single-sample window.
    @(negedge clk); bus1.start = 1'b1;
    @(negedge clk); bus1.start = 1'b0;
    check("max1_busy", bus1.busy, 1'b1);
    bus1.pc_golden = $urandom; bus1.pc_faulty = bus1.pc_golden + 32'd8;
    bus1.result_golden = $urandom; bus1.result_faulty = bus1.result_golden;
    @(negedge clk);
    check("max1_done", {bus1.done, bus1.busy}, 2'b10);
    check("max1_outcome", bus1.outcome, 2'b11);
    check("max1_first", {bus1.first_cycle, bus1.mismatch_count, bus1.first_pc_faulty},
          {16'd0, 16'd1, bus1.pc_golden + 32'd8});
    @(negedge clk);
    check("max1_done_pulse", bus1.done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lockstep_divergence_monitor.md
Name: lockstep_divergence_monitor

Overview:
- Sink-side checker for the golden/faulty lockstep processor pair.
- Samples the golden and faulty PC/Result streams every clock over a bounded run window.
- Captures the first divergence (cycle index plus both PC/Result pairs) and counts all mismatching cycles.
- Classifies the injected fault's outcome as masked, data-only corruption, or control-flow corruption for the fault-campaign harness.

Parameters:
- WIDTH, 32: width of PC and Result buses.
- MAX_CYCLES, 64: number of sampled cycles per run (>=1).
- CNT_W, 16: width of cycle index and mismatch counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin run; sampled in IDLE or DONE.
- abort  input  1  synchronous abort to IDLE; priority over start.
- pc_golden  input  WIDTH  golden PC.
- result_golden  input  WIDTH  golden Result.
- pc_faulty  input  WIDTH  faulty PC.
- result_faulty  input  WIDTH  faulty Result.
- busy  output  1  high in RUN or DIVERGED.
- detected  output  1  sticky: a divergence was seen this run.
- done  output  1  one-cycle pulse on entry to DONE.
- outcome  output  2  00 none/running, 01 masked, 10 data-only, 11 control-flow.
- first_cycle  output  CNT_W  cycle index of first mismatch.
- first_pc_golden  output  WIDTH  captured golden PC at first mismatch.
- first_pc_faulty  output  WIDTH  captured faulty PC at first mismatch.
- first_result_golden  output  WIDTH  captured golden Result at first mismatch.
- first_result_faulty  output  WIDTH  captured faulty Result at first mismatch.
- mismatch_count  output  CNT_W  mismatching cycles this run, saturating.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; internal cycle_cnt=0, pc_div=0.
- States: IDLE, RUN, DIVERGED, DONE.
- Mismatch term per edge: mm = (pc_golden!=pc_faulty) || (result_golden!=result_faulty); pcm = (pc_golden!=pc_faulty).
- IDLE/DONE:
  - start=1 -> RUN.
  - Clears cycle_cnt, mismatch_count, detected, first_*, pc_div and outcome.
  - No sample taken on the start edge; first sample is on the next edge, index 0.
- RUN, each edge:
  - If mm: first_* <= inputs, first_cycle <= cycle_cnt, detected <= 1, mismatch_count <= 1, pc_div <= pcm, go DIVERGED.
  - cycle_cnt increments on every sampled edge.
- DIVERGED, each edge:
  - If mm: mismatch_count increments, saturating at 2^CNT_W-1.
  - pc_div |= pcm.
  - first_* stay frozen.
- Termination:
  - The edge sampling cycle_cnt==MAX_CYCLES-1 moves to DONE from RUN or DIVERGED.
  - A mismatch on that last edge is still captured and counted.
  - outcome <= masked if !detected, control-flow if pc_div, else data-only. All of these use values including the last sample.
- done: high exactly one cycle after entering DONE. outcome and first_* hold until the next start, abort or reset.
- Latency: detected, first_*, mismatch_count are registered and visible the cycle after the sampled edge.
- abort=1 in any state -> IDLE next edge, clearing everything as on reset.
  - abort together with start: abort wins.
  - abort on the terminating edge: no done pulse, outcome 00.
- start asserted in RUN or DIVERGED: ignored.
- Reset mid-run: immediate return to IDLE; no done pulse.
- MAX_CYCLES=1: single sample, then DONE.

Test Plan:
- Identical streams for 64 cycles after start:
  - busy=1 for 64 cycles, then done pulse.
  - outcome=01, detected=0, mismatch_count=0.
- result_faulty differs only at index 5 (golden 0x10, faulty 0x11), PCs equal:
  - detected=1 from index 6.
  - first_cycle=5, first_result_golden/faulty = 0x10/0x11.
  - mismatch_count=1, outcome=10.
- pc_faulty = pc_golden+4 from index 10 through end:
  - first_cycle=10, mismatch_count=54, outcome=11.
- Single result mismatch at index 63 only:
  - first_cycle=63, count=1, outcome=10.
  - done pulses the cycle after.
- abort at index 20 after a mismatch at 12:
  - IDLE, all outputs 0, no done.
  - New start runs clean to outcome=01.
- CNT_W=4, continuous mismatch for 64 cycles:
  - mismatch_count saturates at 15.
  - rst pulsed low mid-run clears all outputs asynchronously.
